v2f_combinator_eval: RTL and testbench

Sequential reference evaluator for lowered `v2f_*` primitive cells. It accepts one operation at a time, with an opcode and two 32-bit signed operands, and returns the result Factorio's arithmetic and decider combinators would produce. The verification flow uses it to cross-check netlists after techmap. It also serves as the hardware golden model behind blueprint-equivalence benches.

---
 rtl/v2f_eval_pkg.sv | 42 ++++
 rtl/v2f_eval_divider.sv | 77 +++++++
 rtl/v2f_combinator_eval.sv | 221 ++++++++++++++++++++++
 tb/tb_v2f_combinator_eval.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/v2f_eval_pkg.sv
// Shared opcode, state and sign-correction definitions for the v2f combinator evaluator.
package v2f_eval_pkg;

    localparam int V2F_MAX_WIDTH = 32;

    typedef enum logic [4:0] {
        OP_ADD = 5'd0,
        OP_SUB,
        OP_MUL,
        OP_DIV,
        OP_MOD,
        OP_AND,
        OP_OR,
        OP_XOR,
        OP_SHL,
        OP_SHR,
        OP_LT,
        OP_LE,
        OP_GT,
        OP_GE,
        OP_EQ,
        OP_NE,
        OP_NEG,
        OP_NOT,
        OP_POW = 5'd18
    } v2f_op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DIVIDE,
        ST_POWER
    } v2f_state_e;

    // Turns an unsigned magnitude back into a two's complement value.
    function automatic logic [V2F_MAX_WIDTH-1:0] v2f_fix_sign(
        input logic [V2F_MAX_WIDTH-1:0] mag,
        input logic                     neg
    );
        return neg ? (~mag + 1'b1) : mag;
    endfunction

endpackage

// File: rtl/v2f_eval_divider.sv
// Restoring divider on unsigned magnitudes: one quotient bit per cycle, WIDTH cycles after start.
module v2f_eval_divider
    import v2f_eval_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic             done_o,
    output logic [WIDTH-1:0] quot_o,
    output logic [WIDTH-1:0] rem_o
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    logic             busy_q, busy_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] dvsr_q, dvsr_d;

    logic [WIDTH:0]   rem_sh;
    logic [WIDTH-1:0] diff;
    logic             ge;

    // The dividend is shifted out of the quotient register as quotient bits shift in.
    assign rem_sh = {rem_q, quot_q[WIDTH-1]};
    assign ge     = (rem_sh >= {1'b0, dvsr_q});
    assign diff   = rem_sh[WIDTH-1:0] - dvsr_q;

    // Results of the final iteration are presented combinationally so the caller can load them on that edge.
    assign quot_o = {quot_q[WIDTH-2:0], ge};
    assign rem_o  = ge ? diff : rem_sh[WIDTH-1:0];
    assign done_o = busy_q && (cnt_q == CNT_W'(1));

    always_comb begin
        busy_d = busy_q;
        cnt_d  = cnt_q;
        quot_d = quot_q;
        rem_d  = rem_q;
        dvsr_d = dvsr_q;
        if (start_i) begin
            busy_d = 1'b1;
            cnt_d  = CNT_W'(WIDTH);
            quot_d = dividend_i;
            rem_d  = '0;
            dvsr_d = divisor_i;
        end else if (busy_q) begin
            quot_d = quot_o;
            rem_d  = rem_o;
            cnt_d  = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
                busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
            quot_q <= '0;
            rem_q  <= '0;
            dvsr_q <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
            quot_q <= quot_d;
            rem_q  <= rem_d;
            dvsr_q <= dvsr_d;
        end
    end

endmodule

// File: rtl/v2f_combinator_eval.sv
// Reference evaluator for Factorio arithmetic/decider combinator semantics.
// Define V2F_EVAL_POW_EN to build the POWER state; otherwise POW reports err like a reserved opcode.
module v2f_combinator_eval
    import v2f_eval_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             err
);

    if (WIDTH < 2 || WIDTH > V2F_MAX_WIDTH) begin : g_bad_width
        $error("v2f_combinator_eval: WIDTH must be within 2..32");
    end

    v2f_state_e       state_q, state_d;
    logic             rst_done_q;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic             err_q, err_d;
    logic             a_neg_q, a_neg_d;
    logic             b_neg_q, b_neg_d;
    logic             b_zero_q, b_zero_d;
    logic             is_mod_q, is_mod_d;

    v2f_op_e                 op_e;
    logic                    accept;
    logic                    div_start;
    logic                    div_done;
    logic [WIDTH-1:0]        div_quot, div_rem;
    logic [WIDTH-1:0]        a_mag, b_mag;
    logic signed [WIDTH-1:0] sa, sb;
    logic [WIDTH-1:0]        alu_y;
    logic                    alu_err;

    assign op_e      = v2f_op_e'(op);
    assign sa        = a;
    assign sb        = b;
    assign a_mag     = a[WIDTH-1] ? (~a + 1'b1) : a;
    assign b_mag     = b[WIDTH-1] ? (~b + 1'b1) : b;
    assign in_ready  = rst_done_q && (state_q == ST_IDLE) && (!out_valid_q || out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = out_valid_q;
    assign y         = y_q;
    assign err       = err_q;

    v2f_eval_divider #(.WIDTH(WIDTH)) u_divider (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_i    (div_start),
        .dividend_i (a_mag),
        .divisor_i  (b_mag),
        .done_o     (div_done),
        .quot_o     (div_quot),
        .rem_o      (div_rem)
    );

`ifdef V2F_EVAL_POW_EN
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] base_q, base_d;
    logic [WIDTH-1:0] exp_q, exp_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] pcnt_q, pcnt_d;
    logic [WIDTH-1:0] pow_acc_nxt;

    assign pow_acc_nxt = exp_q[0] ? WIDTH'(acc_q * base_q) : acc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_q <= '0;
            exp_q  <= '0;
            acc_q  <= '0;
            pcnt_q <= '0;
        end else begin
            base_q <= base_d;
            exp_q  <= exp_d;
            acc_q  <= acc_d;
            pcnt_q <= pcnt_d;
        end
    end
`endif

    // Single-cycle datapath; anything it does not recognise is reported as an error with y = 0.
    always_comb begin
        alu_y   = '0;
        alu_err = 1'b0;
        case (op_e)
            OP_ADD:  alu_y = a + b;
            OP_SUB:  alu_y = a - b;
            OP_MUL:  alu_y = WIDTH'(a * b);
            OP_AND:  alu_y = a & b;
            OP_OR:   alu_y = a | b;
            OP_XOR:  alu_y = a ^ b;
            OP_SHL:  alu_y = a << b[4:0];
            OP_SHR:  alu_y = sa >>> b[4:0];
            OP_LT:   alu_y = WIDTH'(sa <  sb);
            OP_LE:   alu_y = WIDTH'(sa <= sb);
            OP_GT:   alu_y = WIDTH'(sa >  sb);
            OP_GE:   alu_y = WIDTH'(sa >= sb);
            OP_EQ:   alu_y = WIDTH'(sa == sb);
            OP_NE:   alu_y = WIDTH'(sa != sb);
            OP_NEG:  alu_y = ~a + 1'b1;
            OP_NOT:  alu_y = ~a;
            default: alu_err = 1'b1;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        y_d         = y_q;
        err_d       = err_q;
        a_neg_d     = a_neg_q;
        b_neg_d     = b_neg_q;
        b_zero_d    = b_zero_q;
        is_mod_d    = is_mod_q;
        div_start   = 1'b0;
`ifdef V2F_EVAL_POW_EN
        base_d      = base_q;
        exp_d       = exp_q;
        acc_d       = acc_q;
        pcnt_d      = pcnt_q;
`endif
        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    a_neg_d  = a[WIDTH-1];
                    b_neg_d  = b[WIDTH-1];
                    b_zero_d = (b == '0);
                    is_mod_d = (op_e == OP_MOD);
                    if (op_e == OP_DIV || op_e == OP_MOD) begin
                        div_start = 1'b1;
                        state_d   = ST_DIVIDE;
                    end
`ifdef V2F_EVAL_POW_EN
                    else if (op_e == OP_POW) begin
                        base_d  = a;
                        exp_d   = b;
                        acc_d   = WIDTH'(1);
                        pcnt_d  = CNT_W'(WIDTH);
                        state_d = ST_POWER;
                    end
`endif
                    else begin
                        out_valid_d = 1'b1;
                        y_d         = alu_y;
                        err_d       = alu_err;
                    end
                end
            end
            // Quotient sign follows A^B, remainder sign follows A; a zero divisor always yields 0.
            ST_DIVIDE: begin
                if (div_done) begin
                    out_valid_d = 1'b1;
                    err_d       = 1'b0;
                    if (b_zero_q) begin
                        y_d = '0;
                    end else if (is_mod_q) begin
                        y_d = WIDTH'(v2f_fix_sign(V2F_MAX_WIDTH'(div_rem), a_neg_q));
                    end else begin
                        y_d = WIDTH'(v2f_fix_sign(V2F_MAX_WIDTH'(div_quot), a_neg_q ^ b_neg_q));
                    end
                    state_d = ST_IDLE;
                end
            end
`ifdef V2F_EVAL_POW_EN
            ST_POWER: begin
                acc_d  = pow_acc_nxt;
                base_d = WIDTH'(base_q * base_q);
                exp_d  = exp_q >> 1;
                pcnt_d = pcnt_q - CNT_W'(1);
                if (pcnt_q == CNT_W'(1)) begin
                    out_valid_d = 1'b1;
                    err_d       = 1'b0;
                    y_d         = b_neg_q ? '0 : pow_acc_nxt;
                    state_d     = ST_IDLE;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            rst_done_q  <= 1'b0;
            out_valid_q <= 1'b0;
            y_q         <= '0;
            err_q       <= 1'b0;
            a_neg_q     <= 1'b0;
            b_neg_q     <= 1'b0;
            b_zero_q    <= 1'b0;
            is_mod_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            rst_done_q  <= 1'b1;
            out_valid_q <= out_valid_d;
            y_q         <= y_d;
            err_q       <= err_d;
            a_neg_q     <= a_neg_d;
            b_neg_q     <= b_neg_d;
            b_zero_q    <= b_zero_d;
            is_mod_q    <= is_mod_d;
        end
    end

endmodule

// File: tb/tb_v2f_combinator_eval.sv
// Directed self-checking bench for v2f_combinator_eval at WIDTH=32.
module tb_v2f_combinator_eval;
    import v2f_eval_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] y;
    logic        err;

    int nCompared   = 0;
    int nMismatched = 0;
    int seenValid;

    always #5 clk = ~clk;

    v2f_combinator_eval #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .err       (err)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        nCompared++;
        assert (observed === expected) else begin
            nMismatched++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    // Latency counts rising edges from the one that samples the request to the one where out_valid is seen.
    task automatic applyStimulus(input string tag, input logic [4:0] opIn, input logic [31:0] aIn,
                                 input logic [31:0] bIn, input logic [31:0] expY, input logic expErr,
                                 input int expLat);
        int   lat;
        logic got;
        @(negedge clk);
        op       = opIn;
        a        = aIn;
        b        = bIn;
        in_valid = 1'b1;
        #1;
        checkOutput({tag, ".ready"}, {31'b0, in_ready}, 32'd1);
        lat = 0;
        got = 1'b0;
        while (!got && lat < 100) begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            lat++;
            got = out_valid;
        end
        checkOutput({tag, ".latency"}, lat, expLat);
        checkOutput({tag, ".y"}, y, expY);
        checkOutput({tag, ".err"}, {31'b0, err}, {31'b0, expErr});
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        op        = OP_ADD;
        a         = 32'd7;
        b         = 32'hFFFF_FFFD;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset.out_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("reset.y", y, 32'd0);
        checkOutput("reset.err", {31'b0, err}, 32'd0);
        checkOutput("reset.in_ready", {31'b0, in_ready}, 32'd0);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        #1;
        checkOutput("release.in_ready_before_edge", {31'b0, in_ready}, 32'd0);
        @(posedge clk);
        #1;
        checkOutput("release.in_ready_after_edge", {31'b0, in_ready}, 32'd1);

        applyStimulus("add_7_m3", OP_ADD, 32'd7, 32'hFFFF_FFFD, 32'd4, 1'b0, 1);
        applyStimulus("sub_3_10", OP_SUB, 32'd3, 32'd10, 32'hFFFF_FFF9, 1'b0, 1);
        applyStimulus("mul_m6_7", OP_MUL, 32'hFFFF_FFFA, 32'd7, 32'hFFFF_FFD6, 1'b0, 1);

        applyStimulus("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0, 33);
        applyStimulus("mod_m7_2", OP_MOD, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0, 33);
        applyStimulus("div_5_0", OP_DIV, 32'd5, 32'd0, 32'd0, 1'b0, 33);
        applyStimulus("div_min_m1", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 33);
        applyStimulus("mod_7_m3", OP_MOD, 32'd7, 32'hFFFF_FFFD, 32'd1, 1'b0, 33);
        applyStimulus("div_100_7", OP_DIV, 32'd100, 32'd7, 32'd14, 1'b0, 33);

        applyStimulus("shl_1_33", OP_SHL, 32'd1, 32'd33, 32'd2, 1'b0, 1);
        applyStimulus("shr_m8_1", OP_SHR, 32'hFFFF_FFF8, 32'd1, 32'hFFFF_FFFC, 1'b0, 1);
        applyStimulus("lt_m1_0", OP_LT, 32'hFFFF_FFFF, 32'd0, 32'd1, 1'b0, 1);
        applyStimulus("eq_5_6", OP_EQ, 32'd5, 32'd6, 32'd0, 1'b0, 1);
        applyStimulus("ge_m2_m2", OP_GE, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'd1, 1'b0, 1);
        applyStimulus("xor", OP_XOR, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'hFF00_EDCB, 1'b0, 1);
        applyStimulus("neg_5", OP_NEG, 32'd5, 32'd0, 32'hFFFF_FFFB, 1'b0, 1);

        // Backpressure: a held result blocks the next request until it is popped.
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        op        = OP_ADD;
        a         = 32'd2;
        b         = 32'd3;
        in_valid  = 1'b1;
        #1;
        checkOutput("bp.first_ready", {31'b0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        checkOutput("bp.add_valid", {31'b0, out_valid}, 32'd1);
        checkOutput("bp.add_y", y, 32'd5);
        op = OP_MUL;
        a  = 32'd4;
        b  = 32'd5;
        checkOutput("bp.blocked_ready", {31'b0, in_ready}, 32'd0);
        @(posedge clk);
        #1;
        checkOutput("bp.hold_y", y, 32'd5);
        checkOutput("bp.hold_valid", {31'b0, out_valid}, 32'd1);
        checkOutput("bp.hold_ready", {31'b0, in_ready}, 32'd0);
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        checkOutput("bp.release_ready", {31'b0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checkOutput("bp.mul_valid", {31'b0, out_valid}, 32'd1);
        checkOutput("bp.mul_y", y, 32'd20);

`ifdef V2F_EVAL_POW_EN
        applyStimulus("pow_3_4", OP_POW, 32'd3, 32'd4, 32'd81, 1'b0, 33);
        applyStimulus("pow_2_32", OP_POW, 32'd2, 32'd32, 32'd0, 1'b0, 33);
        applyStimulus("pow_5_m1", OP_POW, 32'd5, 32'hFFFF_FFFF, 32'd0, 1'b0, 33);
        applyStimulus("pow_0_0", OP_POW, 32'd0, 32'd0, 32'd1, 1'b0, 33);
`else
        applyStimulus("pow_disabled", OP_POW, 32'd3, 32'd4, 32'd0, 1'b1, 1);
`endif

        applyStimulus("reserved_25", 5'd25, 32'd9, 32'd9, 32'd0, 1'b1, 1);
        applyStimulus("after_err_and", OP_AND, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'h0F00_0F00, 1'b0, 1);

        // Reset in the middle of a division must discard it without a result.
        @(posedge clk);
        @(negedge clk);
        op       = OP_DIV;
        a        = 32'd100;
        b        = 32'd7;
        in_valid = 1'b1;
        #1;
        checkOutput("abort.ready", {31'b0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("abort.valid_in_reset", {31'b0, out_valid}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n     = 1'b1;
        seenValid = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (out_valid) seenValid++;
        end
        checkOutput("abort.no_result", seenValid, 32'd0);
        applyStimulus("abort.add_after", OP_ADD, 32'd11, 32'd31, 32'd42, 1'b0, 1);

        @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
